// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: FSM state
// encoding and the helper that sizes the iteration counter.
package seq_mult_pkg;

  // Controller states; encodings are fixed so they stay stable across builds.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  // Bits needed to count iterations 0..width-1. Clamped to one bit so the
  // counter never collapses to a zero-width vector.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/seq_multiplier_shift_add_stage.sv
// One shift-add step of the multiplier. Purely combinational: conditionally
// adds the multiplicand into the upper half of the accumulator, then shifts
// the whole accumulator right by one. The extra top bit catches the carry.
module shift_add_stage #(
  parameter int width = 5
) (
  input  logic [2*width:0]   i_acc,
  input  logic [width-1:0]   i_mcand,
  input  logic               i_lsb,
  output logic [2*width:0]   o_acc
);

  logic [width:0] w_upper;

  // Conditional add into the upper half, then right shift by one.
  always_comb begin
    w_upper = i_acc[2*width:width];
    if (i_lsb) begin
      w_upper = i_acc[2*width:width] + {1'b0, i_mcand};
    end
    o_acc = {1'b0, w_upper, i_acc[width-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier producing the full 2*width product over
// width+2 cycles. Signed operands are converted to magnitudes at capture and
// the sign is re-applied in FINISH, so the datapath is always unsigned.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int width = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*width-1:0]   y,
  output logic                 ovf
);

  localparam int CNT_W = cnt_width(width);
  localparam int ACC_W = 2 * width + 1;

  state_t               r_state;
  state_t               w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [ACC_W-1:0]     r_acc;
  logic [ACC_W-1:0]     w_acc_next;
  logic [width-1:0]     r_mcand;
  logic [width-1:0]     r_mplier;
  logic                 r_neg;
  logic                 r_signed;
  logic [2*width-1:0]   r_y;
  logic                 r_ovf;
  logic                 r_done;

  logic                 w_last_iter;
  logic                 w_capture;
  logic                 w_calc;
  logic                 w_finish;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [width-1:0]     w_a_mag;
  logic [width-1:0]     w_b_mag;
  logic                 w_neg_in;
  logic [2*width-1:0]   w_mag;
  logic [2*width-1:0]   w_p;
  logic [width:0]       w_sign_bits;
  logic                 w_ovf_u;
  logic                 w_ovf_s;
  logic                 w_ovf_p;

  assign w_last_iter = (r_cnt == CNT_W'(width - 1));

  // Operand conditioning: the most negative value maps to 2^(width-1),
  // which still fits in an unsigned width-bit magnitude.
  always_comb begin
    w_a_neg  = signed_mode & a[width-1];
    w_b_neg  = signed_mode & b[width-1];
    w_a_mag  = w_a_neg ? -a : a;
    w_b_mag  = w_b_neg ? -b : b;
    w_neg_in = w_a_neg ^ w_b_neg;
  end

  // Single datapath stage shared by every CALC iteration.
  shift_add_stage #(
    .width (width)
  ) u_stage (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .i_lsb   (r_mplier[0]),
    .o_acc   (w_acc_next)
  );

  // Result conditioning: re-apply the sign, then test whether the product
  // fits back into width bits for the active mode.
  always_comb begin
    w_mag       = r_acc[2*width-1:0];
    w_p         = r_neg ? -w_mag : w_mag;
    w_ovf_u     = |w_p[2*width-1:width];
    w_sign_bits = w_p[2*width-1:width-1];
    w_ovf_s     = ~((&w_sign_bits) | (~|w_sign_bits));
    w_ovf_p     = r_signed ? w_ovf_s : w_ovf_u;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: CALC runs exactly width iterations, FINISH lasts one.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = CALC;
      CALC:    if (w_last_iter) w_state_next = FINISH;
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State decode into datapath enables and the busy flag.
  always_comb begin
    w_capture = (r_state == IDLE) && start;
    w_calc    = (r_state == CALC);
    w_finish  = (r_state == FINISH);
    busy      = (r_state != IDLE);
  end

  // Operand capture and iteration datapath. Captured values are only
  // reloaded from IDLE, so a start while busy cannot disturb them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_signed <= 1'b0;
    end else if (w_capture) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= w_a_mag;
      r_mplier <= w_b_mag;
      r_neg    <= w_neg_in;
      r_signed <= signed_mode;
    end else if (w_calc) begin
      r_cnt    <= r_cnt + CNT_W'(1);
      r_acc    <= w_acc_next;
      r_mplier <= r_mplier >> 1;
    end
  end

  // Output registers: done pulses for the single cycle after FINISH, while
  // y and ovf hold until the next completed operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_y    <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_y   <= w_p;
        r_ovf <= w_ovf_p;
      end
    end
  end

  assign done = r_done;
  assign y    = r_y;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: table-driven vectors and
// hand-written corner sequences on a width=5 instance, plus a random sweep
// on width=5 and width=8 instances against a behavioural product model.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       s5 = 1'b0, sm5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       busy5, done5, ovf5;
  logic [9:0] y5;

  logic        s8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, ovf8;
  logic [15:0] y8;

  seq_multiplier #(.width(5)) dut5 (
    .clk(clk), .rst(rst), .start(s5), .signed_mode(sm5), .a(a5), .b(b5),
    .busy(busy5), .done(done5), .y(y5), .ovf(ovf5)
  );

  seq_multiplier #(.width(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .signed_mode(sm8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .y(y8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] y;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q5[$];
  exp_t q8[$];
  exp_t m5, m8;
  int   last_done5 = 0;

  typedef struct {
    logic [4:0] a;
    logic [4:0] b;
    logic       sm;
    logic [9:0] y;
    logic       ovf;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer product of the interpreted operands.
  function automatic void model(input int w, input logic [7:0] a, input logic [7:0] b,
                                input logic sm, output logic [15:0] y, output logic ovf);
    longint lim, av, bv, p;
    lim = longint'(1) << w;
    av  = longint'(a) % lim;
    bv  = longint'(b) % lim;
    if (sm && av >= lim / 2) av -= lim;
    if (sm && bv >= lim / 2) bv -= lim;
    p   = av * bv;
    y   = 16'(p & (lim * lim - 1));
    ovf = sm ? (p < -(lim / 2) || p > lim / 2 - 1) : (p >= lim);
  endfunction

  // Scoreboard monitors: pop one expectation per done pulse.
  always @(negedge clk) begin
    if (done5) begin
      if (q5.size() == 0) begin
        check("d5_unexpected_done", 1, 0);
      end else begin
        m5 = q5.pop_front();
        $display("w5 done: y=%0d ovf=%0d (exp y=%0d ovf=%0d)", y5, ovf5, m5.y, m5.ovf);
        check("d5_y", y5, m5.y);
        check("d5_ovf", ovf5, m5.ovf);
        check("d5_latency", cyc - m5.cyc, 6);
        check("d5_busy_in_done", busy5, 0);
      end
      last_done5 = cyc;
    end
  end

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        check("d8_unexpected_done", 1, 0);
      end else begin
        m8 = q8.pop_front();
        $display("w8 done: y=%0d ovf=%0d (exp y=%0d ovf=%0d)", y8, ovf8, m8.y, m8.ovf);
        check("d8_y", y8, m8.y);
        check("d8_ovf", ovf8, m8.ovf);
        check("d8_latency", cyc - m8.cyc, 9);
        check("d8_busy_in_done", busy8, 0);
      end
    end
  end

  // Drive a start in the current cycle, push the expectation at the capture
  // edge, then scramble the operands to prove they were latched.
  task automatic issue_now(input int w, input logic [7:0] a, input logic [7:0] b,
                           input logic sm, input logic [15:0] ey, input logic eo);
    exp_t e;
    if (w == 5) begin a5 = a[4:0]; b5 = b[4:0]; sm5 = sm; s5 = 1'b1; end
    else        begin a8 = a;      b8 = b;      sm8 = sm; s8 = 1'b1; end
    @(posedge clk);
    #1;
    e.y = ey; e.ovf = eo; e.cyc = cyc;
    if (w == 5) begin
      q5.push_back(e);
      s5 = 1'b0; a5 = ~a5; b5 = ~b5; sm5 = ~sm5;
      check("d5_busy_after_capture", busy5, 1);
    end else begin
      q8.push_back(e);
      s8 = 1'b0; a8 = ~a8; b8 = ~b8; sm8 = ~sm8;
      check("d8_busy_after_capture", busy8, 1);
    end
  endtask

  task automatic issue(input int w, input logic [7:0] a, input logic [7:0] b,
                       input logic sm, input logic [15:0] ey, input logic eo);
    @(negedge clk);
    issue_now(w, a, b, sm, ey, eo);
  endtask

  task automatic wait_drain(input int w);
    for (int i = 0; i < 40; i++) begin
      if (((w == 5) ? q5.size() : q8.size()) == 0) return;
      @(negedge clk);
    end
    check("drain_timeout", 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[12];
    logic [15:0] ey;
    logic        eo;
    logic [7:0]  ra, rb;
    logic        rsm;
    int          first_done;
    bit          seen;

    vecs[0]  = '{5'd31, 5'd31, 1'b0, 10'd961,  1'b1};
    vecs[1]  = '{5'd3,  5'd5,  1'b0, 10'd15,   1'b0};
    vecs[2]  = '{5'd0,  5'd31, 1'b0, 10'd0,    1'b0};
    vecs[3]  = '{5'd16, 5'd16, 1'b1, 10'h100,  1'b1};
    vecs[4]  = '{5'd29, 5'd5,  1'b1, 10'h3F1,  1'b0};
    vecs[5]  = '{5'd31, 5'd1,  1'b1, 10'h3FF,  1'b0};
    vecs[6]  = '{5'd15, 5'd15, 1'b1, 10'd225,  1'b1};
    vecs[7]  = '{5'd16, 5'd31, 1'b1, 10'd16,   1'b1};
    vecs[8]  = '{5'd16, 5'd1,  1'b1, 10'h3F0,  1'b0};
    vecs[9]  = '{5'd0,  5'd16, 1'b1, 10'd0,    1'b0};
    vecs[10] = '{5'd31, 5'd1,  1'b0, 10'd31,   1'b0};
    vecs[11] = '{5'd16, 5'd2,  1'b0, 10'd32,   1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy5", busy5, 0);
    check("rst_done5", done5, 0);
    check("rst_y5", y5, 0);
    check("rst_ovf5", ovf5, 0);
    check("rst_busy8", busy8, 0);
    check("rst_y8", y8, 0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      issue(5, {3'b000, vecs[i].a}, {3'b000, vecs[i].b}, vecs[i].sm,
            {6'd0, vecs[i].y}, vecs[i].ovf);
      wait_drain(5);
    end

    // Start while busy with other operands is ignored.
    issue(5, 8'd7, 8'd3, 1'b0, 16'd21, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s5 = 1'b1; a5 = 5'd31; b5 = 5'd31;
    end
    @(negedge clk);
    s5 = 1'b0;
    wait_drain(5);
    repeat (8) @(negedge clk);

    // Back-to-back: start presented during the done cycle.
    issue(5, 8'd6, 8'd5, 1'b0, 16'd30, 1'b0);
    seen = 1'b0;
    first_done = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done5) begin seen = 1'b1; first_done = cyc; end
    end
    check("b2b_first_done_seen", seen, 1);
    issue_now(5, 8'd9, 8'd9, 1'b0, 16'd81, 1'b1);
    wait_drain(5);
    check("b2b_spacing", last_done5 - first_done, 7);

    // Reset during the third CALC cycle aborts without a done pulse.
    issue(5, 8'd31, 8'd31, 1'b0, 16'd961, 1'b1);
    wait_drain(5);
    issue(5, 8'd13, 8'd11, 1'b0, 16'd143, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", busy5, 0);
    check("abort_done", done5, 0);
    check("abort_y", y5, 0);
    check("abort_ovf", ovf5, 0);
    q5.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("abort_no_done", done5, 0);
    issue(5, 8'd7, 8'd9, 1'b0, 16'd63, 1'b1);
    wait_drain(5);

    // Random sweep on both widths against the behavioural model.
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rsm = 1'($urandom_range(0, 1));
      model(5, ra, rb, rsm, ey, eo);
      issue(5, ra, rb, rsm, ey, eo);
      wait_drain(5);
    end
    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rsm = 1'($urandom_range(0, 1));
      if (i < 4) begin ra = 8'h80; rb = (i < 2) ? 8'h80 : 8'hFF; end
      model(8, ra, rb, rsm, ey, eo);
      issue(8, ra, rb, rsm, ey, eo);
      wait_drain(8);
    end

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
